// File: rtl/perceptron_layer_sequencer_if.sv
// Handshake/config bundle for the perceptron layer sequencer.
// master drives start/x_in/cfg_*; slave returns cfg_rej/busy/done/y_out.
interface perceptron_layer_sequencer_if #(
  parameter int W_WIDTH = 8
);
  logic               start;
  logic [3:0]         x_in;
  logic               cfg_we;
  logic [4:0]         cfg_addr;
  logic [W_WIDTH-1:0] cfg_data;
  logic               cfg_rej;
  logic               busy;
  logic               done;
  logic [3:0]         y_out;

  modport master (
    output start, x_in, cfg_we, cfg_addr, cfg_data,
    input  cfg_rej, busy, done, y_out
  );

  modport slave (
    input  start, x_in, cfg_we, cfg_addr, cfg_data,
    output cfg_rej, busy, done, y_out
  );
endinterface

// File: rtl/perceptron_layer_sequencer.sv
// 4x4 perceptron layer stepped through one shared adder, step activation.
// Ports: clk, rst_n (sync, active-low), bus (slave modport of the _if).
module perceptron_layer_sequencer #(
  parameter int W_WIDTH   = 8,
  parameter int THR_RESET = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  perceptron_layer_sequencer_if.slave  bus
);

  localparam int ACC_W = W_WIDTH + 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [W_WIDTH-1:0] w_q   [16];
  logic [W_WIDTH-1:0] thr_q [4];

  logic [3:0]       x_q;
  logic [3:0]       shadow_q;
  logic [3:0]       y_q;
  logic [1:0]       n_q;
  logic [1:0]       i_q;
  logic [ACC_W-1:0] acc_q;
  logic             done_q;
  logic             rej_q;

  logic [W_WIDTH-1:0] w_sel;
  logic [ACC_W-1:0]   sum;
  logic               hit;
  logic               idle;
  logic               last;

  assign idle = (state == S_IDLE);
  assign last = (n_q == 2'd3) && (i_q == 2'd3);

  always_comb begin
    w_sel = w_q[{n_q, i_q}];
    sum   = acc_q + (x_q[i_q] ? ACC_W'(w_sel) : '0);
    hit   = (sum >= ACC_W'(thr_q[n_q]));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (bus.start) state_nx = S_ACC;
      S_ACC:  if (last)      state_nx = S_DONE;
      S_DONE:                state_nx = S_IDLE;
      default:               state_nx = S_IDLE;
    endcase
  end

  // Register file: a write in the start cycle lands before the
  // first ACC read, so that run sees it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 16; k++) w_q[k] <= '0;
      for (int k = 0; k < 4; k++)
        thr_q[k] <= W_WIDTH'(THR_RESET);
    end else if (bus.cfg_we && idle) begin
      unique case (1'b1)
        !bus.cfg_addr[2]:
          w_q[{bus.cfg_addr[4:3], bus.cfg_addr[1:0]}]
            <= bus.cfg_data;
        bus.cfg_addr[2:0] == 3'd4:
          thr_q[bus.cfg_addr[4:3]] <= bus.cfg_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q      <= '0;
      shadow_q <= '0;
      y_q      <= '0;
      n_q      <= '0;
      i_q      <= '0;
      acc_q    <= '0;
      done_q   <= 1'b0;
      rej_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      rej_q  <= bus.cfg_we && !idle;
      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            x_q   <= bus.x_in;
            acc_q <= '0;
            n_q   <= '0;
            i_q   <= '0;
          end
        end
        S_ACC: begin
          if (i_q == 2'd3) begin
            shadow_q[n_q] <= hit;
            acc_q         <= '0;
            i_q           <= '0;
            n_q           <= n_q + 2'd1;
          end else begin
            acc_q <= sum;
            i_q   <= i_q + 2'd1;
          end
        end
        S_DONE: begin
          y_q    <= shadow_q;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = !idle;
  assign bus.done    = done_q;
  assign bus.y_out   = y_q;
  assign bus.cfg_rej = rej_q;

endmodule

// File: tb/tb_perceptron_layer_sequencer.sv
// Directed bench for perceptron_layer_sequencer.
// Expected activations queue up at start and are popped on done.
module tb_perceptron_layer_sequencer;

  logic clk;
  logic rst_n;

  int n_chk  = 0;
  int n_fail = 0;

  logic [3:0] exp_q [$];

  perceptron_layer_sequencer_if #(.W_WIDTH(8)) bus ();

  perceptron_layer_sequencer #(
    .W_WIDTH  (8),
    .THR_RESET(2)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] n,
                           input logic [2:0] slot,
                           input logic [7:0] d);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = {n, slot};
    bus.cfg_data = d;
    tick();
    bus.cfg_we = 1'b0;
    check("rej_idle", 32'(bus.cfg_rej), 0);
  endtask

  task automatic run(input string tag,
                     input logic [3:0] x,
                     input logic [3:0] exp);
    int cyc;
    logic [3:0] e;
    exp_q.push_back(exp);
    bus.x_in  = x;
    bus.start = 1'b1;
    tick();
    bus.start  = 1'b0;
    bus.cfg_we = 1'b0;
    bus.x_in   = ~x;
    check({tag, "_busy"}, 32'(bus.busy), 1);
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    check({tag, "_lat"}, cyc, 17);
    e = exp_q.pop_front();
    check({tag, "_y"}, 32'(bus.y_out), 32'(e));
    check({tag, "_idle"}, 32'(bus.busy), 0);
    tick();
    check({tag, "_pulse"}, 32'(bus.done), 0);
    check({tag, "_hold"}, 32'(bus.y_out), 32'(e));
  endtask

  logic [7:0] wt [16];
  int ndone;
  int dk;

  initial begin
    wt = '{8'd2, 8'd4, 8'd2, 8'd1,
           8'd1, 8'd2, 8'd3, 8'd4,
           8'd1, 8'd2, 8'd4, 8'd2,
           8'd1, 8'd4, 8'd2, 8'd5};
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.x_in     = '0;
    bus.cfg_we   = 1'b0;
    bus.cfg_addr = '0;
    bus.cfg_data = '0;
    tick();
    tick();
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_rej", 32'(bus.cfg_rej), 0);
    check("rst_y", 32'(bus.y_out), 0);
    rst_n = 1'b1;
    tick();

    run("dflt", 4'b1111, 4'b0000);

    // Write in the start cycle is used by that run.
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = 5'b00000;
    bus.cfg_data = 8'd5;
    run("same_cyc", 4'b0001, 4'b0001);

    for (int k = 0; k < 16; k++)
      cfg_write(2'(k / 4), 3'(k % 4), wt[k]);
    for (int n = 0; n < 4; n++)
      cfg_write(2'(n), 3'd4, 8'd5);

    run("prog_f", 4'b1111, 4'b1111);
    run("prog_8", 4'b1000, 4'b1000);
    run("prog_1", 4'b0001, 4'b0000);

    cfg_write(2'd2, 3'd4, 8'd4);
    run("eq_hit", 4'b0100, 4'b0100);
    cfg_write(2'd2, 3'd4, 8'd5);
    run("eq_miss", 4'b0100, 4'b0000);

    // Slots 5..7 must not alias onto the threshold.
    cfg_write(2'd0, 3'd5, 8'hFF);
    cfg_write(2'd0, 3'd7, 8'hFF);
    run("noop", 4'b1111, 4'b1111);

    // Refused write at T+5, ignored start at T+8.
    exp_q.push_back(4'b1111);
    bus.x_in  = 4'b1111;
    bus.start = 1'b1;
    tick();
    ndone = 0;
    dk    = 0;
    for (int k = 1; k <= 20; k++) begin
      bus.cfg_we   = (k == 5);
      bus.cfg_addr = 5'b00100;
      bus.cfg_data = 8'hFF;
      bus.start    = (k == 8);
      bus.x_in     = 4'b0000;
      tick();
      if (k == 5) check("rej_pulse", 32'(bus.cfg_rej), 1);
      if (k == 6) check("rej_fall", 32'(bus.cfg_rej), 0);
      if (k == 16) check("busy_t16", 32'(bus.busy), 1);
      if (k == 17) check("busy_t17", 32'(bus.busy), 0);
      if (bus.done === 1'b1) begin
        ndone++;
        dk = k;
        if (exp_q.size() > 0)
          check("busy_y", 32'(bus.y_out), 32'(exp_q.pop_front()));
      end
    end
    bus.cfg_we = 1'b0;
    bus.start  = 1'b0;
    check("done_count", ndone, 1);
    check("done_edge", dk, 17);
    run("after_rej", 4'b1111, 4'b1111);

    for (int k = 0; k < 16; k++)
      cfg_write(2'(k / 4), 3'(k % 4), 8'hFF);
    for (int n = 0; n < 4; n++)
      cfg_write(2'(n), 3'd4, 8'hFF);
    run("full", 4'b1111, 4'b1111);

    // Reset asserted at edge T+9 of a run.
    bus.x_in  = 4'b1111;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    ndone = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (bus.done === 1'b1) ndone++;
    end
    rst_n = 1'b0;
    tick();
    check("mrst_busy", 32'(bus.busy), 0);
    check("mrst_y", 32'(bus.y_out), 0);
    check("mrst_done", 32'(bus.done), 0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (bus.done === 1'b1) ndone++;
    end
    check("mrst_nodone", ndone, 0);
    check("mrst_idle", 32'(bus.busy), 0);
    run("mrst_dflt", 4'b1111, 4'b0000);

    check("sb_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
